key_event_arbiter: RTL and testbench
====================================

// Module: key_event_arbiter
// PURPOSE
//  Shares the single 11-bit key-event input of the ZX keyboard matrix between 3 requesters:
//  src0 = PS/2 host keys, src1 = joystick-to-key mapper, src2 = OSD autotype/macro player.
//  Grants one event at a time and emits it as a 1-cycle ps2_key pulse.
//  Holds off the next event until the matrix has latched the current one
//  (matrix_update rising edge), so a press/release pair can never collapse between updates.
// PARAMETERS
//  GAP_CYCLES   16         idle clocks after each event before the next grant (0 = none)
//  SYNC_UPDATE  1          1 = wait for matrix_update rising edge after each event; 0 = skip wait
//  UPD_TIMEOUT  1000000    max clocks spent waiting for matrix_update before proceeding anyway
// PORTS
//  clk          in   1    system clock
//  reset        in   1    synchronous, active-high reset
//  src_en       in   3    per-source enable; disabled source is never granted
//  req_valid    in   3    per-source event request; held with data until req_ready
//  req_press    in   3    per-source 1 = press, 0 = release
//  req_code     in   27   per-source 9-bit code; src i at [9i+8:9i]; bit 8 = extended (E0)
//  req_ready    out  3    one-hot accept; transfer = req_valid[i] & req_ready[i]
//  matrix_update in  1    matrix latch strobe from the frame timer
//  ps2_key      out  11   {strobe, press, code[8:0]}; bit 10 high exactly 1 clock per event
//  evt_src      out  2    source of last emitted event; 2'b11 = none since reset
//  busy         out  1    1 whenever state != IDLE
//  upd_timeout  out  1    sticky: a matrix_update wait expired; cleared only by reset
// BEHAVIOUR
//  Reset (sync): state=IDLE, ps2_key=0, evt_src=2'b11, busy=0, upd_timeout=0, rr_ptr=0,
//   all counters 0, matrix_update edge register=0. Reset mid-operation aborts any event; no pulse.
//  req_ready is combinational: req_ready[i] = (state==IDLE) & grant[i]; grant is one-hot or 0.
//  grant computed over eligible = req_valid & src_en; no eligible -> grant=0, stay IDLE.
//  Round robin: search starts at rr_ptr, wraps 2->0; on transfer rr_ptr <= winner+1 (mod 3).
//  Transfer in cycle T -> cycle T+1: ps2_key = {1'b1, req_press[w], req_code[w]},
//   evt_src = w. Cycle T+2: ps2_key[10] = 0; bits 9:0 hold last event.
//  States:
//   IDLE     : on transfer -> PULSE.
//   PULSE    : 1 clock, ps2_key[10]=1 -> WAIT_UPD if SYNC_UPDATE else GAP.
//   WAIT_UPD : counts clocks; exits on first matrix_update rising edge (0 in previous clk,
//              1 in current) detected after PULSE. Counter reaching UPD_TIMEOUT -> set
//              upd_timeout, exit. Exit -> GAP, or IDLE if GAP_CYCLES==0.
//   GAP      : counts GAP_CYCLES clocks, then -> IDLE.
//  Edge present in the same clock as PULSE is ignored (matrix may miss the event).
//  Edge detector runs in all states; rising edge and timeout in same clock -> edge wins, flag not set.
//  src_en deasserted while that source is valid: no grant; an already-accepted event still completes.
//  req_valid dropping before ready is legal (request withdrawn); no partial transfer.
//  Counter widths: $clog2(param+1); counters clear on every state entry.
//  Minimum event spacing: 2 + GAP_CYCLES clocks (SYNC_UPDATE=0), else bounded by frame rate.
// CONFIGURATION
//  KEYARB_FIXED_PRIO_EN defined: fixed priority src0 > src1 > src2; rr_ptr unused, held 0.
//  Not defined: round robin as above. All other behaviour identical.
// TESTING
//  1. src1 press code 9'h16b, SYNC_UPDATE=0, GAP=16 -> req_ready=3'b010 1 clk; next clk
//     ps2_key=11'h76b; following clk ps2_key=11'h36b; evt_src=1.
//  2. all 3 valid from reset, held, SYNC_UPDATE=0 -> grants 0,1,2,0 spaced 18 clks;
//     with KEYARB_FIXED_PRIO_EN -> grants 0,0,0 while src0 stays valid.
//  3. SYNC_UPDATE=1, two queued events on src0 -> second pulse occurs exactly GAP_CYCLES+2 clks
//     after matrix_update edge; no second pulse while matrix_update idles.
//  4. UPD_TIMEOUT=100, matrix_update stuck 0 -> WAIT_UPD exits after 100 clks, upd_timeout=1,
//     stays 1 through later normal events, 0 after reset.
//  5. reset pulsed during WAIT_UPD with src2 still valid -> next clk ps2_key=0, evt_src=3, busy=0;
//     after release src2 re-granted, single pulse.
//  6. src_en=3'b101, src1 valid only -> req_ready stays 0, no pulse for 1000 clks.

Source files
------------

// File: rtl/key_event_arbiter.sv
// key_event_arbiter
//   Shares the single 11-bit key-event input of the ZX keyboard matrix between
//   three requesters (0 = PS/2 host, 1 = joystick mapper, 2 = OSD autotype).
//   One event at a time is granted and emitted as a 1-clock ps2_key strobe.
//   The next grant is held off until the matrix has latched the current event
//   (matrix_update rising edge, bounded by UPD_TIMEOUT) plus GAP_CYCLES idle
//   clocks, so a press/release pair can never collapse between matrix updates.
//
// Parameters
//   GAP_CYCLES   idle clocks after each event before the next grant (0 = none)
//   SYNC_UPDATE  1 = wait for matrix_update rising edge after each event
//   UPD_TIMEOUT  max clocks spent waiting for matrix_update
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   src_en[2:0]    per-source enable
//   req_valid[2:0] per-source request, held with data until accepted
//   req_press[2:0] per-source 1 = press, 0 = release
//   req_code[26:0] per-source 9-bit code, source i at [9i+8:9i]
//   req_ready[2:0] one-hot accept (combinational)
//   matrix_update  matrix latch strobe from the frame timer
//   ps2_key[10:0]  {strobe, press, code}; strobe high one clock per event
//   evt_src[1:0]   source of last emitted event, 2'b11 = none since reset
//   busy           high whenever not idle
//   upd_timeout    sticky: a matrix_update wait expired
//
// Configuration
//   KEYARB_FIXED_PRIO_EN  fixed priority src0 > src1 > src2 instead of round robin

module key_event_arbiter #(
  parameter int GAP_CYCLES  = 16,
  parameter int SYNC_UPDATE = 1,
  parameter int UPD_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  src_en,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_press,
  input  logic [26:0] req_code,
  output logic [2:0]  req_ready,
  input  logic        matrix_update,
  output logic [10:0] ps2_key,
  output logic [1:0]  evt_src,
  output logic        busy,
  output logic        upd_timeout
);

  localparam int GW = (GAP_CYCLES  > 0) ? $clog2(GAP_CYCLES + 1)  : 1;
  localparam int UW = (UPD_TIMEOUT > 0) ? $clog2(UPD_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_UPD, GAP} state_t;

  state_t        state, state_next, after_wait;
  logic [GW-1:0] gap_cnt;
  logic [UW-1:0] upd_cnt;
  logic [1:0]    rr_ptr;
  logic          upd_prev;
  logic          upd_edge;
  logic          set_timeout;
  logic [2:0]    eligible;
  logic [2:0]    grant;
  logic [1:0]    winner;
  logic [2:0]    sum;
  logic          found;
  logic [8:0]    sel_code;
  logic          transfer;

  assign upd_edge  = matrix_update & ~upd_prev;
  assign eligible  = req_valid & src_en;
  assign req_ready = (state == IDLE) ? grant : 3'b000;
  assign transfer  = (state == IDLE) & (|grant);
  assign busy      = (state != IDLE);
  assign after_wait = (GAP_CYCLES > 0) ? GAP : IDLE;

  // Rotating search from rr_ptr; in fixed-priority builds rr_ptr stays 0,
  // which makes the same search a plain src0 > src1 > src2 priority.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      sum = {1'b0, rr_ptr} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (!found && eligible[sum[1:0]]) begin
        found       = 1'b1;
        winner      = sum[1:0];
        grant[sum[1:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    case (winner)
      2'd1:    sel_code = req_code[17:9];
      2'd2:    sel_code = req_code[26:18];
      default: sel_code = req_code[8:0];
    endcase
  end

  always_comb begin
    state_next  = state;
    set_timeout = 1'b0;
    case (state)
      IDLE:     if (transfer) state_next = PULSE;
      PULSE:    state_next = (SYNC_UPDATE != 0) ? WAIT_UPD : after_wait;
      WAIT_UPD: begin
        // A rising edge in the same clock as the expiry takes precedence.
        if (upd_edge) begin
          state_next = after_wait;
        end else if (int'(upd_cnt) >= UPD_TIMEOUT - 1) begin
          state_next  = after_wait;
          set_timeout = 1'b1;
        end
      end
      GAP:      if (int'(gap_cnt) >= GAP_CYCLES - 1) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      upd_cnt     <= '0;
      rr_ptr      <= '0;
      upd_prev    <= 1'b0;
      ps2_key     <= '0;
      evt_src     <= 2'b11;
      upd_timeout <= 1'b0;
    end else begin
      state    <= state_next;
      upd_prev <= matrix_update;

      if (state_next != state) begin
        gap_cnt <= '0;
        upd_cnt <= '0;
      end else begin
        if (state == GAP)      gap_cnt <= gap_cnt + 1'b1;
        if (state == WAIT_UPD) upd_cnt <= upd_cnt + 1'b1;
      end

      if (set_timeout) upd_timeout <= 1'b1;

      if (transfer) begin
        ps2_key <= {1'b1, req_press[winner], sel_code};
        evt_src <= winner;
`ifdef KEYARB_FIXED_PRIO_EN
        rr_ptr  <= '0;
`else
        rr_ptr  <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
`endif
      end else begin
        ps2_key[10] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
module tb_key_event_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [2:0]  a_en = '0, a_valid = '0, a_press = '0, a_ready;
  logic [26:0] a_code = '0;
  logic        a_upd = 1'b0, a_busy, a_tmo;
  logic [10:0] a_key;
  logic [1:0]  a_src;

  logic [2:0]  b_en = '0, b_valid = '0, b_press = '0, b_ready;
  logic [26:0] b_code = '0;
  logic        b_upd = 1'b0, b_busy, b_tmo;
  logic [10:0] b_key;
  logic [1:0]  b_src;

  int checks = 0;
  int errors = 0;
  int seen;

  always #5 clk = ~clk;

  key_event_arbiter #(.GAP_CYCLES(16), .SYNC_UPDATE(0), .UPD_TIMEOUT(1000000)) dut_a (
    .clk(clk), .reset(reset), .src_en(a_en), .req_valid(a_valid), .req_press(a_press),
    .req_code(a_code), .req_ready(a_ready), .matrix_update(a_upd), .ps2_key(a_key),
    .evt_src(a_src), .busy(a_busy), .upd_timeout(a_tmo));

  key_event_arbiter #(.GAP_CYCLES(16), .SYNC_UPDATE(1), .UPD_TIMEOUT(100)) dut_b (
    .clk(clk), .reset(reset), .src_en(b_en), .req_valid(b_valid), .req_press(b_press),
    .req_code(b_code), .req_ready(b_ready), .matrix_update(b_upd), .ps2_key(b_key),
    .evt_src(b_src), .busy(b_busy), .upd_timeout(b_tmo));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

`ifdef KEYARB_FIXED_PRIO_EN
  logic [2:0]  exp_rdy [4] = '{3'b001, 3'b001, 3'b001, 3'b001};
  logic [1:0]  exp_src [4] = '{2'd0, 2'd0, 2'd0, 2'd0};
  logic [10:0] exp_key [4] = '{11'h601, 11'h601, 11'h601, 11'h601};
`else
  logic [2:0]  exp_rdy [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [1:0]  exp_src [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [10:0] exp_key [4] = '{11'h601, 11'h402, 11'h603, 11'h601};
`endif

  initial begin
    // Reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_key",   32'(a_key),   32'h0);
    check("rst_src",   32'(a_src),   32'h3);
    check("rst_busy",  32'(a_busy),  32'h0);
    check("rst_tmo",   32'(a_tmo),   32'h0);
    check("rst_ready", 32'(a_ready), 32'h0);
    check("rst_src_b", 32'(b_src),   32'h3);

    // Single src1 press, no matrix sync
    a_en = 3'b111; a_valid = 3'b010; a_press = 3'b010; a_code = {9'h000, 9'h16b, 9'h000};
    #1 check("t1_ready", 32'(a_ready), 32'h2);
    tick(1);
    check("t1_pulse", 32'(a_key),   32'h76b);
    check("t1_src",   32'(a_src),   32'h1);
    check("t1_ready_off", 32'(a_ready), 32'h0);
    a_valid = 3'b000;
    tick(1);
    check("t1_hold", 32'(a_key), 32'h36b);
    tick(15);
    check("t1_gap_busy", 32'(a_busy), 32'h1);
    tick(1);
    check("t1_idle", 32'(a_busy), 32'h0);

    // All three valid from reset, held
    reset = 1'b1; tick(2); reset = 1'b0;
    tick(1);
    a_press = 3'b101; a_code = {9'h003, 9'h002, 9'h001}; a_valid = 3'b111;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_ready%0d", i), 32'(a_ready), 32'(exp_rdy[i]));
      tick(1);
      check($sformatf("t2_key%0d", i), 32'(a_key), 32'(exp_key[i]));
      check($sformatf("t2_src%0d", i), 32'(a_src), 32'(exp_src[i]));
      tick(16);
      check($sformatf("t2_busy%0d", i), 32'(a_busy), 32'h1);
      tick(1);
    end
    a_valid = 3'b000;

    // Disabled source never granted
    tick(1);
    a_en = 3'b101; a_valid = 3'b010;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (a_ready != 3'b000 || a_key[10]) seen++;
    end
    check("t6_no_grant", 32'(seen), 32'h0);
    a_valid = 3'b000;

    // Matrix-synchronised spacing, two queued src0 events
    tick(1);
    b_en = 3'b111; b_valid = 3'b001; b_press = 3'b001; b_code = 27'h05a;
    #1 check("t3_ready", 32'(b_ready), 32'h1);
    tick(1);
    check("t3_pulse1", 32'(b_key), 32'h65a);
    check("t3_src",    32'(b_src), 32'h0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_key[10] || b_ready != 3'b000) seen++;
    end
    check("t3_wait_hold", 32'(seen), 32'h0);
    check("t3_wait_busy", 32'(b_busy), 32'h1);
    tick(1); b_upd = 1'b1;
    tick(1); b_upd = 1'b0;
    tick(15);
    check("t3_gap_nostrobe", 32'(b_key[10]), 32'h0);
    check("t3_gap_noready",  32'(b_ready),   32'h0);
    tick(1);
    check("t3_idle_ready", 32'(b_ready), 32'h1);
    tick(1);
    check("t3_pulse2", 32'(b_key), 32'h65a);
    b_valid = 3'b000;

    // matrix_update stuck low: timeout after 100 clocks
    tick(100);
    check("t4_tmo_before", 32'(b_tmo), 32'h0);
    tick(1);
    check("t4_tmo_set",  32'(b_tmo),  32'h1);
    check("t4_tmo_busy", 32'(b_busy), 32'h1);
    tick(16);
    check("t4_idle", 32'(b_busy), 32'h0);
    b_press = 3'b000; b_code = 27'h0aa; b_valid = 3'b001;
    #1 check("t4_ready", 32'(b_ready), 32'h1);
    tick(1);
    check("t4_release", 32'(b_key), 32'h4aa);
    b_valid = 3'b000;
    tick(3); b_upd = 1'b1;
    tick(1); b_upd = 1'b0;
    tick(16);
    check("t4_idle2",   32'(b_busy), 32'h0);
    check("t4_sticky",  32'(b_tmo),  32'h1);

    // Reset during WAIT_UPD with src2 held
    b_press = 3'b100; b_code = {9'h1c3, 18'h0}; b_valid = 3'b100;
    #1 check("t5_ready", 32'(b_ready), 32'h4);
    tick(1);
    check("t5_pulse", 32'(b_key), 32'h7c3);
    check("t5_src",   32'(b_src), 32'h2);
    tick(5);
    reset = 1'b1;
    tick(1);
    check("t5_rst_key",  32'(b_key),  32'h0);
    check("t5_rst_src",  32'(b_src),  32'h3);
    check("t5_rst_busy", 32'(b_busy), 32'h0);
    check("t5_rst_tmo",  32'(b_tmo),  32'h0);
    reset = 1'b0;
    tick(1);
    check("t5_regrant_key", 32'(b_key), 32'h7c3);
    check("t5_regrant_src", 32'(b_src), 32'h2);
    b_valid = 3'b000;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b_key[10]) seen++;
    end
    check("t5_single_pulse", 32'(seen), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
